// File: rtl/bb_core_mc.sv
// bb_core_mc -- multi-cycle accumulator-free register core.
//
// Each instruction is fetched over a single shared memory port. Two-word
// instructions (LDI, LD, ST, JMP, JZ) are followed by an operand fetch. The
// core then spends one EXEC cycle and, for LD/ST, one MEM access.
//
// Memory handshake: the core holds o_mem_req together with a stable
// o_mem_addr, o_mem_we and o_mem_wdata until the memory answers with
// i_mem_ack. i_mem_ack may arrive in the same cycle as the request.
// i_mem_rdata is sampled only in the ack cycle. While the bus is idle,
// every bus output is driven to zero.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   o_mem_req    memory access request
//   o_mem_we     1 = write, 0 = read (meaningful while o_mem_req=1)
//   o_mem_addr   access address
//   o_mem_wdata  store data
//   i_mem_rdata  read data, valid in the ack cycle
//   i_mem_ack    access complete
//   o_pc         current program counter
//   o_halted     core stopped on HALT
//   dbg_state    current FSM state (debug visibility)
module bb_core_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_NUM = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halted,
  output logic [2:0]            dbg_state
);

  localparam int RIDX = $clog2(REG_NUM);

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_OPERAND = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] opr;
  // Only the decoded fields of the instruction word are kept; the low bits
  // below rs carry no meaning.
  logic [3:0]            ir_op;
  logic [RIDX-1:0]       ir_rd;
  logic [RIDX-1:0]       ir_rs;
  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  logic [3:0]            f_op;
  logic [RIDX-1:0]       f_rd;
  logic [RIDX-1:0]       f_rs;
  logic [DATA_WIDTH-1:0] val_rd;
  logic [DATA_WIDTH-1:0] val_rs;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_wr;

  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_JMP) || (op == OP_JZ);
  endfunction

  // Field split of the word arriving in a FETCH ack cycle.
  assign f_op = i_mem_rdata[DATA_WIDTH-1 -: 4];
  assign f_rd = i_mem_rdata[DATA_WIDTH-5 -: RIDX];
  assign f_rs = i_mem_rdata[DATA_WIDTH-5-RIDX -: RIDX];

  // Both operands are read from the current register contents, so rd==rs
  // naturally uses the old value (ADD r1,r1 doubles r1).
  assign val_rd = regs[ir_rd];
  assign val_rs = regs[ir_rs];

  always_comb begin
    alu_res = val_rd;
    alu_wr  = 1'b0;
    case (ir_op)
      OP_LDI:  begin alu_res = opr;             alu_wr = 1'b1; end
      OP_ADD:  begin alu_res = val_rd + val_rs; alu_wr = 1'b1; end
      OP_SUB:  begin alu_res = val_rd - val_rs; alu_wr = 1'b1; end
      OP_AND:  begin alu_res = val_rd & val_rs; alu_wr = 1'b1; end
      OP_OR:   begin alu_res = val_rd | val_rs; alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = val_rd ^ val_rs; alu_wr = 1'b1; end
      OP_MOV:  begin alu_res = val_rs;          alu_wr = 1'b1; end
      default: begin alu_res = val_rd;          alu_wr = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      opr   <= '0;
      ir_op <= '0;
      ir_rd <= '0;
      ir_rs <= '0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (i_mem_ack) begin
            ir_op <= f_op;
            ir_rd <= f_rd;
            ir_rs <= f_rs;
            pc    <= pc + DATA_WIDTH'(1);
            state <= is_two_word(f_op) ? S_OPERAND : S_EXEC;
          end
        end
        S_OPERAND: begin
          if (i_mem_ack) begin
            opr   <= i_mem_rdata;
            pc    <= pc + DATA_WIDTH'(1);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (alu_wr) regs[ir_rd] <= alu_res;
          state <= S_FETCH;
          case (ir_op)
            OP_JMP:       pc <= opr;
            OP_JZ:        if (val_rs == '0) pc <= opr;
            OP_LD, OP_ST: state <= S_MEM;
            OP_HALT:      state <= S_HALT;
            default:      ;
          endcase
        end
        S_MEM: begin
          if (i_mem_ack) begin
            if (ir_op == OP_LD) regs[ir_rd] <= i_mem_rdata;
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // The bus is decoded from the registered state. rst gates the request
  // directly so nothing is requested while reset is held, even though the
  // reset state is FETCH.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (!rst) begin
      case (state)
        S_FETCH, S_OPERAND: begin
          o_mem_req  = 1'b1;
          o_mem_addr = pc;
        end
        S_MEM: begin
          o_mem_req  = 1'b1;
          o_mem_addr = opr;
          if (ir_op == OP_ST) begin
            o_mem_we    = 1'b1;
            o_mem_wdata = val_rs;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pc      = pc;
  assign o_halted  = (state == S_HALT);
  assign dbg_state = state;

endmodule
